// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwards and selects the two ALU operands,
// then holds them in a two-entry skid buffer toward execute.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [1:0]        a_sel,
  input  logic [1:0]        b_sel,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   op_a,
  output logic [XLEN-1:0]   op_b
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic [XLEN-1:0] main_a_q, main_a_d;
  logic [XLEN-1:0] main_b_q, main_b_d;
  logic [XLEN-1:0] skid_a_q, skid_a_d;
  logic [XLEN-1:0] skid_b_q, skid_b_d;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] new_a, new_b;
  logic            acc, xfer;

  // Forwarding: EX/MEM beats MEM/WB, x0 never forwarded.
  always_comb begin
    rs1_fwd = rs1_data;
    if (rs1_addr != '0 && wb_we && wb_rd == rs1_addr)
      rs1_fwd = wb_data;
    if (rs1_addr != '0 && mem_we && mem_rd == rs1_addr)
      rs1_fwd = mem_data;
    rs2_fwd = rs2_data;
    if (rs2_addr != '0 && wb_we && wb_rd == rs2_addr)
      rs2_fwd = wb_data;
    if (rs2_addr != '0 && mem_we && mem_rd == rs2_addr)
      rs2_fwd = mem_data;
  end

  // Operand source muxes; unused encodings give zero.
  always_comb begin
    new_a = '0;
    new_b = '0;
    case (a_sel)
      2'd0:    new_a = rs1_fwd;
      2'd1:    new_a = pc;
      default: new_a = '0;
    endcase
    case (b_sel)
      2'd0:    new_b = rs2_fwd;
      2'd1:    new_b = imm;
      2'd2:    new_b = FOUR;
      default: new_b = '0;
    endcase
  end

  assign acc       = in_valid & rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign xfer      = out_valid & out_ready;
  assign in_ready  = rdy_q;
  assign op_a      = main_a_q;
  assign op_b      = main_b_q;

  // Skid buffer next-state and data movement.
  always_comb begin
    state_d  = state_q;
    main_a_d = main_a_q;
    main_b_d = main_b_q;
    skid_a_d = skid_a_q;
    skid_b_d = skid_b_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d  = ONE;
            main_a_d = new_a;
            main_b_d = new_b;
          end
        end
        ONE: begin
          if (acc && xfer) begin
            main_a_d = new_a;
            main_b_d = new_b;
          end else if (acc) begin
            state_d  = FULL;
            skid_a_d = new_a;
            skid_b_d = new_b;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (xfer) begin
            state_d  = ONE;
            main_a_d = skid_a_q;
            main_b_d = skid_b_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = (state_d != FULL);
  end

  // State, ready flag and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rdy_q    <= 1'b1;
      main_a_q <= '0;
      main_b_q <= '0;
      skid_a_q <= '0;
      skid_b_q <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      main_a_q <= main_a_d;
      main_b_q <= main_b_d;
      skid_a_q <= skid_a_d;
      skid_b_q <= skid_b_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: queue model plus
// hand-computed directed expectations.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [1:0]  a_sel, b_sel;
  logic        mem_we, wb_we;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] op_a, op_b;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  bit m_acc, m_xf;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .a_sel(a_sel), .b_sel(b_sel),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src(logic [4:0] a, logic [31:0] d);
    if (a == 0) return d;
    if (mem_we && mem_rd == a) return mem_data;
    if (wb_we && wb_rd == a) return wb_data;
    return d;
  endfunction

  function automatic logic [31:0] exp_a();
    if (a_sel == 0) return src(rs1_addr, rs1_data);
    if (a_sel == 1) return pc;
    return 0;
  endfunction

  function automatic logic [31:0] exp_b();
    if (b_sel == 0) return src(rs2_addr, rs2_data);
    if (b_sel == 1) return imm;
    if (b_sel == 2) return 4;
    return 0;
  endfunction

  // Reference FIFO of capacity two.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_xf  = out_ready && (q.size() > 0);
      if (m_xf) void'(q.pop_front());
      if (m_acc) q.push_back({exp_a(), exp_b()});
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_b", op_b, 0);
    end else begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      if (q.size() > 0) begin
        chk("op_a", op_a, q[0][63:32]);
        chk("op_b", op_b, q[0][31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(logic [31:0] r1, logic [31:0] r2,
                      logic [31:0] im, logic [31:0] p,
                      logic [1:0] as, logic [1:0] bs);
    in_valid = 1; rs1_data = r1; rs2_data = r2;
    imm = im; pc = p; a_sel = as; b_sel = bs;
    rs1_addr = 1; rs2_addr = 2;
    mem_we = 0; wb_we = 0; mem_rd = 0; wb_rd = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; flush = 0;
    rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
    rs1_addr = 0; rs2_addr = 0; a_sel = 0; b_sel = 0;
    mem_we = 0; wb_we = 0; mem_rd = 0; wb_rd = 0;
    mem_data = 0; wb_data = 0;
    repeat (2) step();
    rst_n = 1;
    #1;

    // Basic accept, one-cycle latency
    beat(32'h10, 0, 32'hFFFF_FFF0, 0, 0, 1);
    step();
    chk("basic_valid", {31'b0, out_valid}, 1);
    chk("basic_a", op_a, 32'h10);
    chk("basic_b", op_b, 32'hFFFF_FFF0);

    // Forwarding priority
    beat(32'h55, 0, 0, 0, 0, 0);
    rs1_addr = 5; mem_we = 1; mem_rd = 5; mem_data = 32'hAA;
    wb_we = 1; wb_rd = 5; wb_data = 32'hBB;
    step();
    chk("fwd_mem", op_a, 32'hAA);
    mem_we = 0;
    step();
    chk("fwd_wb", op_a, 32'hBB);
    mem_we = 1; rs1_addr = 0; rs1_data = 0; mem_rd = 0; wb_rd = 0;
    step();
    chk("fwd_x0", op_a, 32'h0);

    // Constant sources
    beat(32'h77, 0, 0, 32'h100, 1, 2);
    step();
    chk("const_a_pc", op_a, 32'h100);
    chk("const_b_4", op_b, 32'h4);
    a_sel = 2;
    step();
    chk("const_a_zero", op_a, 32'h0);
    in_valid = 0;
    step();

    // Backpressure with three offered beats
    out_ready = 0;
    beat(1, 1, 0, 0, 0, 0);
    step();
    beat(2, 2, 0, 0, 0, 0);
    step();
    chk("bp_ready_low", {31'b0, in_ready}, 0);
    beat(3, 3, 0, 0, 0, 0);
    step();
    chk("bp_hold_a", op_a, 1);
    chk("bp_still_full", {31'b0, in_ready}, 0);
    out_ready = 1;
    #0 chk("bp_out1", op_a, 1);
    step();
    chk("bp_out2", op_a, 2);
    step();
    chk("bp_out3", op_a, 3);
    in_valid = 0;
    step();
    chk("bp_drained", {31'b0, out_valid}, 0);

    // Flush while full with a beat presented
    out_ready = 0;
    beat(32'h21, 0, 0, 0, 0, 0);
    step();
    beat(32'h22, 0, 0, 0, 0, 0);
    step();
    flush = 1;
    beat(32'h23, 0, 0, 0, 0, 0);
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_ready", {31'b0, in_ready}, 1);
    step();
    chk("flush_gone", {31'b0, out_valid}, 0);

    // Mixed valid/ready traffic with forwarding
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rs1_addr  = 5'($urandom_range(0, 3));
      rs2_addr  = 5'($urandom_range(0, 3));
      mem_rd    = 5'($urandom_range(0, 3));
      wb_rd     = 5'($urandom_range(0, 3));
      mem_we    = 1'($urandom_range(0, 1));
      wb_we     = 1'($urandom_range(0, 1));
      a_sel     = 2'($urandom_range(0, 3));
      b_sel     = 2'($urandom_range(0, 3));
      rs1_data  = $urandom; rs2_data = $urandom;
      imm       = $urandom; pc = $urandom;
      mem_data  = $urandom; wb_data = $urandom;
      step();
    end

    // Asynchronous reset while full
    out_ready = 0;
    beat(32'h31, 32'h41, 0, 0, 0, 0);
    step();
    step();
    step();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_a", op_a, 0);
    chk("arst_b", op_b, 0);
    chk("arst_ready", {31'b0, in_ready}, 1);
    step();
    out_ready = 1;
    beat(32'h99, 32'h98, 0, 0, 0, 0);
    #2 rst_n = 1;
    step();
    chk("post_rst_valid", {31'b0, out_valid}, 1);
    chk("post_rst_a", op_a, 32'h99);
    chk("post_rst_b", op_b, 32'h98);
    in_valid = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand and data width in bits.
REQ-002 The block SHALL have parameter REG_AW, default 5: register-address width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have the following upstream ports:
- in_valid, input, 1: request present.
- in_ready, output, 1: stage can accept.
- rs1_data, rs2_data, imm, pc, input, XLEN each: candidate sources.
- rs1_addr, rs2_addr, input, REG_AW each: source register numbers.
- a_sel, input, 2: A source. 0=RS1, 1=PC, 2=ZERO.
- b_sel, input, 2: B source. 0=RD2, 1=EXTEND, 2=CONST4.
REQ-006 The block SHALL have the following forwarding ports:
- mem_we, input, 1; mem_rd, input, REG_AW; mem_data, input, XLEN: EX/MEM forward path.
- wb_we, input, 1; wb_rd, input, REG_AW; wb_data, input, XLEN: MEM/WB forward path.
REQ-007 The block SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-008 The block SHALL have the following downstream ports:
- out_valid, output, 1: operands present.
- out_ready, input, 1: consumer accepts.
- op_a, op_b, output, XLEN each: selected operands.

Function
REQ-009 Accept SHALL occur when in_valid and in_ready are both 1 on a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-010 Operand resolution SHALL be combinational at accept and stored as computed.
- Registered values SHALL NOT be re-resolved after accept.
REQ-011 Forwarded RS1 SHALL be:
- mem_data if mem_we=1, mem_rd==rs1_addr and rs1_addr!=0;
- otherwise wb_data if wb_we=1, wb_rd==rs1_addr and rs1_addr!=0;
- otherwise rs1_data.
REQ-012 Forwarded RS2 SHALL follow the REQ-011 rule using rs2_addr and rs2_data.
REQ-013 Register 0 SHALL never be forwarded, regardless of the write enables.
REQ-014 op_a SHALL be forwarded RS1 for a_sel=0, pc for 1, and 0 for 2; a_sel=3 SHALL yield 0.
REQ-015 op_b SHALL be forwarded RS2 for b_sel=0, imm for 1, and XLEN-wide value 4 for 2; b_sel=3 SHALL yield 0.
REQ-016 Storage SHALL be a two-entry skid buffer: a main register feeding the outputs and a skid register.
REQ-017 The buffer state machine SHALL have three states: EMPTY, ONE (main valid), FULL (main and skid valid).
REQ-018 State transitions SHALL be:
- EMPTY + accept -> ONE.
- ONE + accept without transfer -> FULL.
- ONE + transfer without accept -> EMPTY.
- ONE + accept and transfer -> ONE, with the new data in main.
- FULL + transfer -> ONE, with skid data moved to main.
- All other cases SHALL hold state.
REQ-019 in_ready SHALL be a registered signal, equal to 1 exactly when the state is not FULL.
REQ-020 out_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-021 Latency SHALL be 1 cycle: data accepted while EMPTY appears on op_a/op_b with out_valid=1 on the next cycle.
REQ-022 Throughput SHALL be one transfer per cycle with out_ready held at 1.
REQ-023 Ordering SHALL be strict FIFO; no entry SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-024 op_a/op_b SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 flush=1 SHALL force EMPTY on the next edge, with priority over accept and transfer.
- Any input presented in the flush cycle SHALL be dropped.
- in_ready SHALL be 1 on the following cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously force:
- state EMPTY;
- out_valid=0;
- in_ready=1;
- op_a=0 and op_b=0;
- skid data=0.
REQ-027 Reset release SHALL take effect synchronously to clk; the first accept SHALL be possible on the first edge after release.
REQ-028 Reset asserted mid-operation SHALL discard all held entries with no partial output.

Verification
REQ-029 Basic: reset, a_sel=0, b_sel=1, rs1_data=0x10, imm=0xFFFFFFF0, no forwarding, out_ready=1 -> next cycle out_valid=1, op_a=0x10, op_b=0xFFFFFFF0.
REQ-030 Forward priority: rs1_addr=5, mem_we=1, mem_rd=5, mem_data=0xAA, wb_we=1, wb_rd=5, wb_data=0xBB -> op_a=0xAA.
- Same case with mem_we=0 -> op_a=0xBB.
- Same case with rs1_addr=0 and rs1_data=0x0 -> op_a=0x0.
REQ-031 Backpressure: out_ready=0, present three beats with values 1, 2, 3 -> beats 1 and 2 accepted and in_ready=0 after the second.
- Then raise out_ready -> outputs 1, 2, 3 in order, one per cycle after stall release.
REQ-032 Constants: a_sel=1, pc=0x100, b_sel=2 -> op_a=0x100, op_b=4; a_sel=2 -> op_a=0.
REQ-033 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed and presented beats are never output.
REQ-034 Reset while FULL -> out_valid=0 and op_a=op_b=0 immediately, without waiting for a clock edge.
